i2c_cam_cfg_seq: RTL and testbench

//  Table-driven camera register configuration sequencer. Walks REG_NUM {reg_addr,reg_data}

---
 rtl/i2c_cam_cfg_seq.sv | 176 +++++++++++++++++
 tb/tb_i2c_cam_cfg_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cam_cfg_seq.sv
// Camera register configuration sequencer: walks a {reg_addr,reg_data} ROM table and
// issues one I2C write per entry, with power-up/soft-reset waits, delay entries and NACK retry.
module i2c_cam_cfg_seq #(
  parameter int                REG_NUM    = 70,
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter int                ROM_AW     = 8,
  parameter int                PWRUP_DLY  = 1023,
  parameter int                RST_IDX    = 0,
  parameter int                RST_DLY    = 1023,
  parameter logic [ADDR_W-1:0] DLY_TAG    = {ADDR_W{1'b1}},
  parameter int                DLY_UNIT   = 1000,
  parameter int                MAX_RETRY  = 3,
  parameter int                AUTO_START = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [ROM_AW-1:0]        rom_addr,
  input  logic [ADDR_W+DATA_W-1:0] rom_data,
  output logic                     i2c_exec,
  output logic [ADDR_W-1:0]        i2c_addr,
  output logic [DATA_W-1:0]        i2c_wdata,
  input  logic                     i2c_done,
  input  logic                     i2c_nack,
  output logic                     busy,
  output logic                     init_done,
  output logic                     init_err,
  output logic [ROM_AW-1:0]        err_idx
);

  localparam int ENT_MAX = (2**DATA_W - 1) * DLY_UNIT;
  localparam int FIX_MAX = (PWRUP_DLY > RST_DLY) ? PWRUP_DLY : RST_DLY;
  localparam int CNT_MAX = (FIX_MAX > ENT_MAX) ? FIX_MAX : ENT_MAX;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  // One extra bit so the index can reach REG_NUM == 2**ROM_AW without wrapping.
  localparam int IDX_W   = ROM_AW + 1;
  localparam int RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_PWR_WAIT, ST_FETCH, ST_LOAD, ST_EXEC, ST_WAIT, ST_DELAY, ST_DONE, ST_ERR
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [RTY_W-1:0]   retry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               auto_pend_r;
  logic [IDX_W-1:0]   idx_nxt_s;
  logic [ADDR_W-1:0]  ent_addr_s;
  logic [DATA_W-1:0]  ent_data_s;

  assign idx_nxt_s  = idx_r + IDX_W'(1);
  assign ent_addr_s = rom_data[ADDR_W+DATA_W-1:DATA_W];
  assign ent_data_s = rom_data[DATA_W-1:0];

  // Counter preload for an N-cycle wait; a zero request still costs one cycle.
  function automatic logic [CNT_W-1:0] fixed_load(input int n);
    return (n < 1) ? CNT_W'(0) : CNT_W'(n - 1);
  endfunction

  function automatic logic [CNT_W-1:0] entry_load(input logic [DATA_W-1:0] units);
    logic [CNT_W-1:0] cycles;
    cycles = CNT_W'(units) * CNT_W'(DLY_UNIT);
    return (units == {DATA_W{1'b0}}) ? CNT_W'(0) : cycles - CNT_W'(1);
  endfunction

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      retry_r     <= '0;
      cnt_r       <= '0;
      auto_pend_r <= (AUTO_START != 0);
      rom_addr    <= '0;
      i2c_exec    <= 1'b0;
      i2c_addr    <= '0;
      i2c_wdata   <= '0;
      busy        <= 1'b0;
      init_done   <= 1'b0;
      init_err    <= 1'b0;
      err_idx     <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start || (state_r == ST_IDLE && auto_pend_r)) begin
            state_r     <= ST_PWR_WAIT;
            busy        <= 1'b1;
            init_done   <= 1'b0;
            init_err    <= 1'b0;
            err_idx     <= '0;
            idx_r       <= '0;
            retry_r     <= '0;
            cnt_r       <= fixed_load(PWRUP_DLY);
            auto_pend_r <= 1'b0;
          end
        end
        ST_PWR_WAIT: begin
          if (cnt_r == CNT_W'(0)) begin
            state_r  <= ST_FETCH;
            rom_addr <= '0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_FETCH: state_r <= ST_LOAD;
        ST_LOAD: begin
          if (ent_addr_s == DLY_TAG) begin
            state_r <= ST_DELAY;
            cnt_r   <= entry_load(ent_data_s);
            idx_r   <= idx_nxt_s;
          end else begin
            state_r   <= ST_EXEC;
            i2c_addr  <= ent_addr_s;
            i2c_wdata <= ent_data_s;
            i2c_exec  <= 1'b1;
          end
        end
        ST_EXEC: begin
          i2c_exec <= 1'b0;
          state_r  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i2c_done) begin
            if (!i2c_nack) begin
              retry_r <= '0;
              idx_r   <= idx_nxt_s;
              if (idx_r == IDX_W'(RST_IDX)) begin
                state_r <= ST_DELAY;
                cnt_r   <= fixed_load(RST_DLY);
              end else if (idx_nxt_s == IDX_W'(REG_NUM)) begin
                state_r   <= ST_DONE;
                busy      <= 1'b0;
                init_done <= 1'b1;
              end else begin
                state_r  <= ST_FETCH;
                rom_addr <= idx_nxt_s[ROM_AW-1:0];
              end
            end else if (retry_r < RTY_W'(MAX_RETRY)) begin
              retry_r  <= retry_r + RTY_W'(1);
              i2c_exec <= 1'b1;
              state_r  <= ST_EXEC;
            end else begin
              state_r  <= ST_ERR;
              busy     <= 1'b0;
              init_err <= 1'b1;
              err_idx  <= idx_r[ROM_AW-1:0];
            end
          end
        end
        // Shared by delay entries and the post-soft-reset wait; idx already points past the entry.
        ST_DELAY: begin
          if (cnt_r == CNT_W'(0)) begin
            if (idx_r == IDX_W'(REG_NUM)) begin
              state_r   <= ST_DONE;
              busy      <= 1'b0;
              init_done <= 1'b1;
            end else begin
              state_r  <= ST_FETCH;
              rom_addr <= idx_r[ROM_AW-1:0];
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          busy     <= 1'b0;
          i2c_exec <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cam_cfg_seq.sv
// Scoreboard bench for i2c_cam_cfg_seq: ROM and I2C master models, expected writes queued
// from the table and NACK plan, compared against the writes the DUT actually issues.
module tb_i2c_cam_cfg_seq;
  localparam int REG_NUM = 4, ADDR_W = 16, DATA_W = 8, ROM_AW = 8;
  localparam int PWRUP_DLY = 20, RST_DLY = 30, DLY_UNIT = 10, MAX_RETRY = 3, MLAT = 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [ROM_AW-1:0] rom_addr, err_idx;
  logic [23:0] rom_data = 24'h0;
  logic i2c_exec, busy, init_done, init_err;
  logic [ADDR_W-1:0] i2c_addr;
  logic [DATA_W-1:0] i2c_wdata;
  logic m_done = 1'b0, m_nack = 1'b0, stray_done = 1'b0;
  logic i2c_done;
  assign i2c_done = m_done | stray_done;

  logic [23:0] rom [0:255];
  logic [23:0] exp_q[$], exec_q[$], done_q[$];
  int exec_cyc_q[$], done_cyc_q[$];
  bit nack_q[$];
  int cyc = 0, rel_cyc = 0, checks = 0, passes = 0;

  i2c_cam_cfg_seq #(
    .REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_AW(ROM_AW),
    .PWRUP_DLY(PWRUP_DLY), .RST_IDX(0), .RST_DLY(RST_DLY), .DLY_TAG(16'hFFFF),
    .DLY_UNIT(DLY_UNIT), .MAX_RETRY(MAX_RETRY), .AUTO_START(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c_exec(i2c_exec), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata), .i2c_done(i2c_done),
    .i2c_nack(m_nack), .busy(busy), .init_done(init_done), .init_err(init_err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  // I2C master model: logs each write, answers MLAT cycles later with the planned ACK/NACK.
  initial begin
    bit aborted;
    logic nk;
    forever begin
      @(posedge clk); #1;
      while (i2c_exec === 1'b1 && rst_n === 1'b1) begin
        exec_q.push_back({i2c_addr, i2c_wdata});
        exec_cyc_q.push_back(cyc);
        nk = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        aborted = 1'b0;
        for (int k = 0; k < MLAT; k++) begin
          @(posedge clk); #1;
          if (rst_n !== 1'b1) aborted = 1'b1;
        end
        if (!aborted) begin
          done_q.push_back({i2c_addr, i2c_wdata});
          done_cyc_q.push_back(cyc);
          m_done = 1'b1; m_nack = nk;
          @(posedge clk); #1;
          m_done = 1'b0; m_nack = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic set_table(input bit with_delay);
    rom[0] = {16'h0103, 8'h01};
    rom[1] = {16'h3008, 8'h82};
    rom[2] = with_delay ? {16'hFFFF, 8'd5} : {16'h3103, 8'h03};
    rom[3] = {16'h4800, 8'h24};
  endtask

  task automatic clear_q();
    exp_q.delete(); exec_q.delete(); done_q.delete();
    exec_cyc_q.delete(); done_cyc_q.delete(); nack_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear_q();
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic pulse_start(output int s_cyc);
    @(posedge clk); #1;
    start = 1'b1; s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok, output logic fd, output logic fe);
    ok = 1'b0; fd = 1'bx; fe = 1'bx;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) begin
        ok = 1'b1; fd = init_done; fe = init_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) rom[i] = 24'h0;
    set_table(1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, init_done, init_err, i2c_exec} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {busy, init_done, init_err, i2c_exec});
    else passes++;
    checks++;
    if ({i2c_addr, i2c_wdata} !== 24'h0)
      $display("FAIL reset_bus: got %h want 000000", {i2c_addr, i2c_wdata});
    else passes++;
    checks++;
    if ({rom_addr, err_idx} !== 16'h0) $display("FAIL reset_idx: got %h want 0000", {rom_addr, err_idx});
    else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) $display("FAIL auto_start_busy: got %b want 1", busy);
    else passes++;
  endtask

  task automatic test_basic();
    bit ok; logic fd, fe; logic [23:0] e, a, d;
    set_table(1'b0);
    do_reset();
    for (int i = 0; i < REG_NUM; i++) exp_q.push_back(rom[i]);
    wait_idle(3000, ok, fd, fe);
    checks++;
    if (!ok || fd !== 1'b1 || fe !== 1'b0)
      $display("FAIL basic_done: ok=%0d init_done=%b init_err=%b want 1/1/0", ok, fd, fe);
    else passes++;
    checks++;
    if (exec_cyc_q.size() < 1 || exec_cyc_q[0] - rel_cyc != PWRUP_DLY + 3)
      $display("FAIL basic_first_exec: got %0d want %0d", (exec_cyc_q.size() > 0) ? exec_cyc_q[0] - rel_cyc : -1, PWRUP_DLY + 3);
    else passes++;
    checks++;
    if (exec_cyc_q.size() < 2 || exec_cyc_q[1] - done_cyc_q[0] != RST_DLY + 3)
      $display("FAIL basic_rst_gap: got %0d want %0d", (exec_cyc_q.size() > 1) ? exec_cyc_q[1] - done_cyc_q[0] : -1, RST_DLY + 3);
    else passes++;
    for (int i = 2; i < REG_NUM; i++) begin
      checks++;
      if (exec_cyc_q.size() <= i || exec_cyc_q[i] - done_cyc_q[i-1] != 3)
        $display("FAIL basic_gap%0d: got %0d want 3", i, (exec_cyc_q.size() > i) ? exec_cyc_q[i] - done_cyc_q[i-1] : -1);
      else passes++;
    end
    checks++;
    if (rom_addr !== 8'd3) $display("FAIL basic_rom_addr: got %0d want 3", rom_addr);
    else passes++;
    checks++;
    if (exec_q.size() != exp_q.size()) $display("FAIL basic_count: got %0d want %0d", exec_q.size(), exp_q.size());
    else passes++;
    while (exp_q.size() > 0 && exec_q.size() > 0 && done_q.size() > 0) begin
      e = exp_q.pop_front(); a = exec_q.pop_front(); d = done_q.pop_front();
      checks++;
      if (a !== e || d !== e) $display("FAIL basic_write: exec %h done %h want %h", a, d, e);
      else passes++;
    end
  endtask

  task automatic test_delay_entry();
    bit ok; logic fd, fe; logic [23:0] e, a, d;
    set_table(1'b1);
    do_reset();
    exp_q.push_back(rom[0]); exp_q.push_back(rom[1]); exp_q.push_back(rom[3]);
    wait_idle(3000, ok, fd, fe);
    checks++;
    if (!ok || fd !== 1'b1) $display("FAIL delay_done: ok=%0d init_done=%b want 1/1", ok, fd);
    else passes++;
    // Delay entry: its own FETCH+LOAD, the wait itself, then FETCH/LOAD/EXEC of the next entry.
    checks++;
    if (exec_cyc_q.size() < 3 || exec_cyc_q[2] - done_cyc_q[1] != 5 * DLY_UNIT + 5)
      $display("FAIL delay_gap: got %0d want %0d", (exec_cyc_q.size() > 2) ? exec_cyc_q[2] - done_cyc_q[1] : -1, 5 * DLY_UNIT + 5);
    else passes++;
    checks++;
    if (exec_q.size() != exp_q.size()) $display("FAIL delay_count: got %0d want %0d", exec_q.size(), exp_q.size());
    else passes++;
    while (exp_q.size() > 0 && exec_q.size() > 0 && done_q.size() > 0) begin
      e = exp_q.pop_front(); a = exec_q.pop_front(); d = done_q.pop_front();
      checks++;
      if (a !== e || d !== e) $display("FAIL delay_write: exec %h done %h want %h", a, d, e);
      else passes++;
    end
  endtask

  task automatic test_nack_retry();
    bit ok; logic fd, fe; logic [23:0] e, a, d;
    set_table(1'b0);
    do_reset();
    nack_q = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_q = {rom[0], rom[1], rom[1], rom[1], rom[2], rom[3]};
    wait_idle(3000, ok, fd, fe);
    checks++;
    if (!ok || fd !== 1'b1 || fe !== 1'b0) $display("FAIL retry_done: ok=%0d init_done=%b init_err=%b", ok, fd, fe);
    else passes++;
    checks++;
    if (exec_cyc_q.size() < 4 || exec_cyc_q[2] - done_cyc_q[1] != 1 || exec_cyc_q[3] - done_cyc_q[2] != 1)
      $display("FAIL retry_gap: got %0d want 1", (exec_cyc_q.size() > 2) ? exec_cyc_q[2] - done_cyc_q[1] : -1);
    else passes++;
    checks++;
    if (exec_q.size() != exp_q.size()) $display("FAIL retry_count: got %0d want %0d", exec_q.size(), exp_q.size());
    else passes++;
    while (exp_q.size() > 0 && exec_q.size() > 0 && done_q.size() > 0) begin
      e = exp_q.pop_front(); a = exec_q.pop_front(); d = done_q.pop_front();
      checks++;
      if (a !== e || d !== e) $display("FAIL retry_write: exec %h done %h want %h", a, d, e);
      else passes++;
    end
  endtask

  task automatic test_nack_err();
    bit ok; logic fd, fe; logic [23:0] e, a, d;
    set_table(1'b0);
    do_reset();
    nack_q = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_q = {rom[0], rom[1], rom[2], rom[3], rom[3], rom[3], rom[3]};
    wait_idle(3000, ok, fd, fe);
    checks++;
    if (!ok || fd !== 1'b0 || fe !== 1'b1)
      $display("FAIL err_flags: ok=%0d init_done=%b init_err=%b want 1/0/1", ok, fd, fe);
    else passes++;
    checks++;
    if (err_idx !== 8'd3 || busy !== 1'b0) $display("FAIL err_idx: got %0d busy %b want 3 busy 0", err_idx, busy);
    else passes++;
    checks++;
    if (exec_q.size() != exp_q.size()) $display("FAIL err_count: got %0d want %0d", exec_q.size(), exp_q.size());
    else passes++;
    while (exp_q.size() > 0 && exec_q.size() > 0 && done_q.size() > 0) begin
      e = exp_q.pop_front(); a = exec_q.pop_front(); d = done_q.pop_front();
      checks++;
      if (a !== e || d !== e) $display("FAIL err_write: exec %h done %h want %h", a, d, e);
      else passes++;
    end
  endtask

  // DUT is in ERR here: start reruns; a start and a stray done during PWR_WAIT must be ignored.
  task automatic test_start_after_err();
    bit ok; logic fd, fe; int s; logic [23:0] e, a;
    clear_q();
    for (int i = 0; i < REG_NUM; i++) exp_q.push_back(rom[i]);
    pulse_start(s);
    checks++;
    if ({busy, init_done, init_err} !== 3'b100 || err_idx !== 8'd0)
      $display("FAIL start_clear: got busy/done/err=%b err_idx=%0d want 100/0", {busy, init_done, init_err}, err_idx);
    else passes++;
    repeat (3) @(posedge clk);
    #1;
    stray_done = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0; start = 1'b0;
    wait_idle(3000, ok, fd, fe);
    checks++;
    if (!ok || fd !== 1'b1) $display("FAIL start_done: ok=%0d init_done=%b want 1/1", ok, fd);
    else passes++;
    checks++;
    if (exec_cyc_q.size() < 1 || exec_cyc_q[0] - s != PWRUP_DLY + 3)
      $display("FAIL start_first_exec: got %0d want %0d", (exec_cyc_q.size() > 0) ? exec_cyc_q[0] - s : -1, PWRUP_DLY + 3);
    else passes++;
    checks++;
    if (exec_q.size() != exp_q.size()) $display("FAIL start_count: got %0d want %0d", exec_q.size(), exp_q.size());
    else passes++;
    while (exp_q.size() > 0 && exec_q.size() > 0) begin
      e = exp_q.pop_front(); a = exec_q.pop_front();
      checks++;
      if (a !== e) $display("FAIL start_write: exec %h want %h", a, e);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic fd, fe; int s; bit seen;
    clear_q();
    for (int i = 0; i < REG_NUM; i++) exp_q.push_back(rom[i]);
    pulse_start(s);
    checks++;
    if (init_done !== 1'b0 || busy !== 1'b1) $display("FAIL rerun_clear: init_done=%b busy=%b want 0/1", init_done, busy);
    else passes++;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (exec_q.size() >= 2);
    end
    checks++;
    if (!seen || init_done !== 1'b0) $display("FAIL rerun_mid: seen=%0d init_done=%b want 1/0", seen, init_done);
    else passes++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(3000, ok, fd, fe);
    checks++;
    if (!ok || fd !== 1'b1 || exec_q.size() != exp_q.size())
      $display("FAIL rerun_end: ok=%0d init_done=%b execs=%0d want 1/1/%0d", ok, fd, exec_q.size(), exp_q.size());
    else passes++;
    checks++;
    if (exec_q.size() < 4 || exec_q[3] !== exp_q[3] || exec_q[0] !== exp_q[0])
      $display("FAIL rerun_write: first %h last %h want %h %h", (exec_q.size() > 0) ? exec_q[0] : 24'h0,
               (exec_q.size() > 3) ? exec_q[3] : 24'h0, exp_q[0], exp_q[3]);
    else passes++;
  endtask

  task automatic test_reset_mid_wait();
    bit ok; logic fd, fe; bit seen;
    set_table(1'b0);
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (exec_q.size() >= 1);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || {busy, init_done, init_err, i2c_exec, i2c_addr, i2c_wdata, rom_addr, err_idx} !== 44'h0)
      $display("FAIL midreset_outputs: seen=%0d busy=%b exec=%b addr=%h wdata=%h rom_addr=%0d want all 0",
               seen, busy, i2c_exec, i2c_addr, i2c_wdata, rom_addr);
    else passes++;
    repeat (3) @(posedge clk);
    #1;
    clear_q();
    rst_n = 1'b1;
    rel_cyc = cyc;
    wait_idle(3000, ok, fd, fe);
    checks++;
    if (!ok || fd !== 1'b1 || exec_q.size() != REG_NUM)
      $display("FAIL midreset_rerun: ok=%0d init_done=%b execs=%0d want 1/1/%0d", ok, fd, exec_q.size(), REG_NUM);
    else passes++;
    checks++;
    if (exec_cyc_q.size() < 1 || exec_cyc_q[0] - rel_cyc != PWRUP_DLY + 3)
      $display("FAIL midreset_first_exec: got %0d want %0d", (exec_cyc_q.size() > 0) ? exec_cyc_q[0] - rel_cyc : -1, PWRUP_DLY + 3);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay_entry();
    test_nack_retry();
    test_nack_err();
    test_start_after_err();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
